// File: rtl/csa_stream_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : csa_stream_accumulator_if
// Description : Operand-in / result-out valid-ready bundle for the
//               carry-save stream accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface csa_stream_accumulator_if #(
  parameter int WIDTH = 32,
  parameter int GUARD = 8
) ();
  localparam int ACC_W = WIDTH + GUARD;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : csa_stream_accumulator
// Description : Carry-save multi-operand packet accumulator with a segmented
//               carry-propagate resolve. Optional macro CSA_ACC_OVF_EN builds
//               the sticky per-packet overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_stream_accumulator #(
  parameter int WIDTH = 32,
  parameter int GUARD = 8,
  parameter int CHUNK = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  csa_stream_accumulator_if.slave    bus
);
  localparam int ACC_W  = WIDTH + GUARD;
  localparam int NCHUNK = ACC_W / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_s;
  logic [ACC_W-1:0]   r_c;
  logic [ACC_W-1:0]   r_res;
  logic [IDX_W-1:0]   r_idx;
  logic               r_cin;
  logic               r_in_ready;
  logic               r_out_valid;

  logic               w_accept;
  logic [ACC_W-1:0]   w_x;
  logic [ACC_W-1:0]   w_sum_next;
  logic [ACC_W-1:0]   w_carry_next;
  logic [CHUNK:0]     w_chunk_sum;

  assign w_accept   = bus.in_valid && r_in_ready;
  assign w_x        = ACC_W'(bus.in_data);
  assign w_sum_next = r_s ^ r_c ^ w_x;
  // Majority shifted up one place; the bit leaving the top is the dropped carry.
  assign w_carry_next = ((r_s & r_c) | (r_s & w_x) | (r_c & w_x)) << 1;

  assign w_chunk_sum = {1'b0, r_s[r_idx*CHUNK +: CHUNK]}
                     + {1'b0, r_c[r_idx*CHUNK +: CHUNK]}
                     + (CHUNK+1)'(r_cin);

`ifdef CSA_ACC_OVF_EN
  logic r_ovf;
  logic w_drop;
  assign w_drop = (r_s[ACC_W-1] & r_c[ACC_W-1])
                | (r_s[ACC_W-1] & w_x[ACC_W-1])
                | (r_c[ACC_W-1] & w_x[ACC_W-1]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_s         <= '0;
      r_c         <= '0;
      r_res       <= '0;
      r_idx       <= '0;
      r_cin       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef CSA_ACC_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_s <= w_sum_next;
            r_c <= w_carry_next;
`ifdef CSA_ACC_OVF_EN
            r_ovf <= r_ovf | w_drop;
`endif
            if (bus.in_last) begin
              r_state    <= ST_RESOLVE;
              r_idx      <= '0;
              r_cin      <= 1'b0;
              r_in_ready <= 1'b0;
            end
          end
        end

        ST_RESOLVE: begin
          r_res[r_idx*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
          r_cin                       <= w_chunk_sum[CHUNK];
          if (r_idx == IDX_W'(NCHUNK - 1)) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
`ifdef CSA_ACC_OVF_EN
            r_ovf <= r_ovf | w_chunk_sum[CHUNK];
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        ST_DONE: begin
          // res is deliberately left alone so out_data keeps the last total.
          if (bus.out_ready) begin
            r_state     <= ST_ACCUM;
            r_s         <= '0;
            r_c         <= '0;
            r_idx       <= '0;
            r_cin       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef CSA_ACC_OVF_EN
            r_ovf       <= 1'b0;
`endif
          end
        end

        default: begin
          r_state     <= ST_ACCUM;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_res;
`ifdef CSA_ACC_OVF_EN
  assign bus.out_ovf   = r_ovf;
`else
  assign bus.out_ovf   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_stream_accumulator
// Description : Directed, table-driven bench for csa_stream_accumulator at
//               default parameters plus a small-width random-packet instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_stream_accumulator;
  localparam bit OVF_EN =
`ifdef CSA_ACC_OVF_EN
    1'b1;
`else
    1'b0;
`endif

  localparam int c_lat  = 5;
  localparam int c_lat8 = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  csa_stream_accumulator_if #(.WIDTH(32), .GUARD(8)) bus ();
  csa_stream_accumulator_if #(.WIDTH(8),  .GUARD(0)) bus8 ();

  csa_stream_accumulator #(.WIDTH(32), .GUARD(8), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  csa_stream_accumulator #(.WIDTH(8), .GUARD(0), .CHUNK(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  typedef struct {
    int          beats;
    logic [31:0] val;
    logic [39:0] exp_data;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic send_burst(input logic [31:0] d, input int n);
    for (int b = 0; b < n; b++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = (b == n - 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [39:0] ed, input bit eo);
    int cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({name, "_latency"}, 64'(cnt), 64'(c_lat));
    chk({name, "_data"}, 64'(bus.out_data), 64'(ed));
    chk({name, "_ovf"}, 64'(bus.out_ovf), 64'(eo));
  endtask

  task automatic handshake(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, "_hs_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({name, "_hs_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    vecs[0] = '{1,   32'h0000_0005, 40'h00_0000_0005, 1'b0};
    vecs[1] = '{3,   32'hFFFF_FFFF, 40'h02_FFFF_FFFD, 1'b0};
    vecs[2] = '{256, 32'hFFFF_FFFF, 40'hFF_FFFF_FF00, 1'b0};
    vecs[3] = '{257, 32'hFFFF_FFFF, 40'h00_FFFF_FEFF, OVF_EN};
    vecs[4] = '{2,   32'h8000_0000, 40'h01_0000_0000, 1'b0};
    vecs[5] = '{1,   32'h0000_0000, 40'h00_0000_0000, 1'b0};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.in_last   = 1'b0;
    bus8.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    for (int v = 0; v < 6; v++) begin
      send_burst(vecs[v].val, vecs[v].beats);
      wait_result($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_ovf);
      handshake($sformatf("vec%0d", v));
    end

    // Beats 1,2,3 with idle gaps carrying junk that must be ignored.
    for (int b = 1; b <= 3; b++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0000_DEAD;
        bus.in_last  = 1'b1;
        @(posedge clk); #1;
      end
      send_beat(32'(b), b == 3);
    end
    wait_result("gaps", 40'h6, 1'b0);

    // Backpressure: offered beats must be refused and the result held.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0100;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_out_data", 64'(bus.out_data), 64'h6);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    handshake("gaps");
    send_beat(32'h7, 1'b1);
    wait_result("after_hs", 40'h7, 1'b0);
    handshake("after_hs");

    // Reset while resolving.
    send_beat(32'h0000_0ABC, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_resolve_out_valid_pre", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_resolve_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_resolve_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_resolve_out_data", 64'(bus.out_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(32'h10, 1'b0);
    send_beat(32'h20, 1'b1);
    wait_result("post_rst", 40'h30, 1'b0);
    handshake("post_rst");

    // Narrow instance: random packets against an integer model.
    for (int p = 0; p < 6; p++) begin
      int          len;
      longint      sum;
      int          cnt;
      logic [7:0]  v8;
      len = (p == 0) ? 1 : (p == 1) ? 300 : $urandom_range(1, 300);
      sum = 0;
      for (int b = 0; b < len; b++) begin
        v8 = 8'($urandom_range(0, 255));
        sum += longint'(v8);
        bus8.in_valid = 1'b1;
        bus8.in_data  = v8;
        bus8.in_last  = (b == len - 1);
        @(posedge clk); #1;
      end
      bus8.in_valid = 1'b0;
      bus8.in_last  = 1'b0;
      cnt = 0;
      while (!bus8.out_valid && cnt < 40) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk($sformatf("w8_p%0d_latency", p), 64'(cnt), 64'(c_lat8));
      chk($sformatf("w8_p%0d_data", p), 64'(bus8.out_data), 64'(sum[7:0]));
      chk($sformatf("w8_p%0d_ovf", p), 64'(bus8.out_ovf), 64'(OVF_EN && (sum >= 256)));
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      chk($sformatf("w8_p%0d_hs_in_ready", p), 64'(bus8.in_ready), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csa_stream_accumulator.md
# csa_stream_accumulator

Parametrised multi-operand accumulator. Folds a packet of unsigned operands, one per cycle, into a running carry-save (sum, carry) pair through a WIDTH+GUARD-bit 3:2 compressor row. On the packet's last beat it resolves the redundant pair with a segmented carry-propagate adder, CHUNK bits per cycle, and presents one result beat on a valid/ready output. It sits between operand producers, such as partial-product or dot-product engines, and downstream consumers that need a single resolved total per packet.

## Interface
- WIDTH, 32, operand width in bits (>= 1)
- GUARD, 8, extra accumulator bits above WIDTH; ACC_W = WIDTH + GUARD
- CHUNK, 8, bits resolved per cycle by the carry-propagate adder; ACC_W % CHUNK == 0 is required, and NCHUNK = ACC_W / CHUNK
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  WIDTH  unsigned operand, zero-extended to ACC_W
- in_last  in  1  final beat of the packet; sampled only on an accepted beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  ACC_W  packet total modulo 2^ACC_W
- out_ovf  out  1  true total >= 2^ACC_W (only with CSA_ACC_OVF_EN; otherwise tied 0)

## Operation
- States: ACCUM, RESOLVE, DONE. Reset state is ACCUM with S = C = 0.
- in_ready = (state == ACCUM). out_valid = (state == DONE).
- Accepted beat (in_valid && in_ready at posedge):
  - Compress: S' = S ^ C ^ X, C' = maj(S, C, X) << 1, where X = zext(in_data).
  - Bit ACC_W of the shifted carry is dropped. With the macro, it is ORed into a sticky ovf register.
- If in_last is set on the accepted beat, go to RESOLVE with chunk index 0 and chunk carry-in 0.
- A single-beat packet (first beat has in_last) is legal.
- RESOLVE, one chunk per cycle:
  - res[i*CHUNK +: CHUNK] = S_chunk + C_chunk + cin.
  - The chunk carry-out is registered as the next cin.
  - After chunk NCHUNK-1, go to DONE. The final carry-out ORs into ovf.
- DONE: out_data = res and out_ovf = ovf, both held stable while out_ready is low.
- On out_valid && out_ready: clear S, C, ovf and the chunk counter, and return to ACCUM. res keeps its last value until overwritten.
- Arithmetic is unsigned, modulo 2^ACC_W. The dropped-carry OR is exact, so ovf = 1 iff the true total >= 2^ACC_W.
- In RESOLVE and DONE, input beats are not accepted, because in_ready = 0.
- in_valid gaps within a packet leave S and C unchanged.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - state = ACCUM, S = C = res = ovf = 0.
  - out_valid = 0, out_data = 0, out_ovf = 0.
  - in_ready = 1 while in reset and immediately after.
- Throughput in ACCUM: one operand per cycle, with no CPA in the accumulate path.
- Latency: last beat accepted at edge k, out_valid high after edge k + NCHUNK (5 cycles at defaults).
- Result handshake at edge m: out_valid low and in_ready high after edge m. A new beat can be accepted at edge m+1.
- Reset asserted mid-packet, mid-RESOLVE or in DONE: all state clears at once and out_valid drops without a handshake. The partial packet is discarded.
- in_last and in_data are ignored when the beat is not accepted.

## Configuration
- CSA_ACC_OVF_EN defined: the sticky ovf register and its logic are built, and out_ovf reports overflow per packet.
- CSA_ACC_OVF_EN undefined: no ovf register, dropped carries are simply discarded, and out_ovf is constant 0.
- Port list is identical in both builds.

## Test plan
- Single beat 0x5 with in_last -> out_valid exactly 5 cycles after acceptance; out_data 0x00_00000005, out_ovf 0.
- Three back-to-back beats 0xFFFFFFFF (last on the third) -> out_data 0x02_FFFFFFFD, out_ovf 0.
- 257 beats of 0xFFFFFFFF:
  - With the macro -> out_data 0x00_FFFFFEFF, out_ovf 1.
  - Without the macro -> same out_data, out_ovf 0.
  - 256 beats -> 0xFF_FFFFFF00, out_ovf 0.
- Beats 1, 2, 3 with random in_valid gaps, then out_ready held low for 10 cycles:
  - in_ready stays 0 and out_data 0x06 stays stable throughout.
  - On release, a next packet beat 0x7 is accepted one cycle after the handshake and yields 0x07.
- rst_n pulsed low during RESOLVE:
  - out_valid 0 and in_ready 1 immediately.
  - A following packet of 0x10 + 0x20 yields 0x30 with no residue.
- Parameter sweep (WIDTH=8, GUARD=0, CHUNK=4; WIDTH=16, GUARD=4, CHUNK=20) against a reference model with random packets of length 1..300.
